// File: rtl/rv_pkg.sv
// Shared RV32I datapath widths and types used by decode, regfile and writeback.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = $clog2(NREG);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;
endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: NREG:1 mux over the register view, address 0 forced to zero.
module regfile_rdport #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [AW-1:0]             addr,
  output logic [XLEN-1:0]           data
);

  always_comb begin
    data = '0;
    for (int i = 1; i < NREG; i++) begin
      if (addr == AW'(i)) data = regs[i];
    end
  end

endmodule

// File: rtl/regfile.sv
// RV32I integer register file: x0 hardwired to zero, two zero-latency read ports,
// one write port committed on the rising edge; async active-high reset clears all.
module regfile #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data,
  input  logic            i_rd_wren
);

  // x0 has no storage; slot 0 of the read view is a constant zero.
  logic [NREG-1:1][XLEN-1:0] mem;
  logic [NREG-1:0][XLEN-1:0] view;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mem <= '0;
    end else if (i_rd_wren) begin
      for (int i = 1; i < NREG; i++) begin
        if (i_rd_addr == AW'(i)) mem[i] <= i_rd_data;
      end
    end
  end

  assign view = {mem, {XLEN{1'b0}}};

  regfile_rdport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rs1 (
    .regs (view),
    .addr (i_rs1_addr),
    .data (o_rs1_data)
  );

  regfile_rdport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rs2 (
    .regs (view),
    .addr (i_rs2_addr),
    .data (o_rs2_data)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: expected reads queued from a shadow model, compared mid-cycle.
module tb_regfile;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic [4:0]  i_rd_addr = '0;
  logic [31:0] i_rd_data = '0;
  logic        i_rd_wren = 1'b0;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow[32];
  int          n_tests = 0;
  int          n_fail = 0;

  regfile dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .i_rd_data  (i_rd_data),
    .i_rd_wren  (i_rd_wren)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_rd(input string tag);
    exp_t e;
    e.tag = tag;
    e.e1  = shadow[i_rs1_addr];
    e.e2  = shadow[i_rs2_addr];
    sb.push_back(e);
  endtask

  task automatic compare_rd();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    check({e.tag, "/rs1"}, o_rs1_data, e.e1);
    check({e.tag, "/rs2"}, o_rs2_data, e.e2);
  endtask

  // Drive one cycle; reads are checked before the edge so a same-cycle write must not bypass.
  task automatic cycle(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] data, input logic wr);
    i_rs1_addr = rs1;
    i_rs2_addr = rs2;
    i_rd_addr  = rd;
    i_rd_data  = data;
    i_rd_wren  = wr;
    expect_rd(tag);
    #2;
    compare_rd();
    @(posedge i_clk);
    if (wr && rd != 5'd0 && !i_reset) shadow[rd] = data;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Async reset before any clock edge.
    #1;
    i_reset    = 1'b1;
    i_rs1_addr = 5'd0;
    i_rs2_addr = 5'd31;
    expect_rd("rst_no_edge");
    #1;
    compare_rd();

    cycle("rst_hold_wr", 5'd5, 5'd31, 5'd5, 32'hFFFF_FFFF, 1'b1);
    cycle("rst_wr_ignored", 5'd5, 5'd0, 5'd0, 32'h0, 1'b0);
    i_reset = 1'b0;

    cycle("wr_x1_old", 5'd1, 5'd1, 5'd1, 32'hDEAD_BEEF, 1'b1);
    cycle("rd_x1", 5'd1, 5'd0, 5'd0, 32'h0, 1'b0);
    cycle("wr_x0", 5'd1, 5'd0, 5'd0, 32'h1234_5678, 1'b1);
    cycle("rd_x0", 5'd0, 5'd1, 5'd0, 32'h0, 1'b0);
    cycle("wr_x31", 5'd31, 5'd1, 5'd31, 32'hCAFE_BABE, 1'b1);
    cycle("rd_x31", 5'd31, 5'd1, 5'd0, 32'h0, 1'b0);
    cycle("nowren_x31", 5'd31, 5'd31, 5'd31, 32'h0, 1'b0);
    cycle("hold_x31", 5'd31, 5'd1, 5'd0, 32'h0, 1'b0);

    // Reset pulse between edges must clear outputs without a clock.
    i_rs1_addr = 5'd1;
    i_rs2_addr = 5'd31;
    i_rd_wren  = 1'b0;
    expect_rd("pre_mid_rst");
    #1;
    compare_rd();
    i_reset = 1'b1;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    expect_rd("mid_rst");
    #1;
    compare_rd();
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    cycle("post_rst", 5'd1, 5'd31, 5'd0, 32'h0, 1'b0);
    cycle("post_rst_x2", 5'd2, 5'd30, 5'd0, 32'h0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      cycle("rnd", 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
            rd, $urandom, 1'($urandom_range(0, 1)));
    end

    // Final sweep of every register against the shadow model.
    for (int r = 0; r < 32; r++) cycle("sweep", 5'(r), 5'(31 - r), 5'd0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
